// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared FSM encoding and BCD digit limits for the stopwatch.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] HUND_LIM     = 4'd9;
    localparam logic [BCD_W-1:0] SEC_ONES_LIM = 4'd9;
    localparam logic [BCD_W-1:0] SEC_TENS_LIM = 4'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sw_state_t;

endpackage
`default_nettype wire

// File: rtl/lim_digit.sv
`default_nettype none
// ============================================================================
//  Module      : lim_digit
//  Description : Single BCD digit limited incrementor with carry chain ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module lim_digit
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] L = 4'd9
) (
    input  logic [BCD_W-1:0] a,
    input  logic             ci,
    output logic [BCD_W-1:0] sum,
    output logic             co
);

    logic w_at_lim;

    assign w_at_lim = (a == L);
    assign co       = w_at_lim & ci;
    assign sum      = co ? '0 : (a + {{(BCD_W-1){1'b0}}, ci});

endmodule
`default_nettype wire

// File: rtl/stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_counter
//  Description : Hundredth-second prescaler, start/stop/clear FSM and the
//                ss.hh BCD digit chain (00.00 .. 59.99, wrapping).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1_000_000,
    parameter int CNT_W    = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    output logic             running,
    output logic             tick,
    output logic [BCD_W-1:0] hund_ones,
    output logic [BCD_W-1:0] hund_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TICK_DIV - 1);

    sw_state_t        r_state;
    sw_state_t        w_next;
    logic [CNT_W-1:0] r_presc;
    logic             r_running;
    logic             w_tick;
    logic             w_zero;

    logic [BCD_W-1:0] r_d0, r_d1, r_d2, r_d3;
    logic [BCD_W-1:0] w_s0, w_s1, w_s2, w_s3;
    logic             w_c0, w_c1, w_c2, w_wrap;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (!clear && start_stop) w_next = RUN;
            end
            RUN: begin
                if (start_stop) w_next = HOLD;
            end
            HOLD: begin
                if (clear)           w_next = IDLE;
                else if (start_stop) w_next = RUN;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_running <= (w_next == RUN);
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: frozen in HOLD so a resume keeps the partial interval
    // ------------------------------------------------------------------
    assign w_tick = (r_state == RUN) && (r_presc == c_LAST);

    always_ff @(posedge clk) begin
        if (reset || (w_next == IDLE)) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            r_presc <= w_tick ? '0 : (r_presc + CNT_W'(1));
        end
    end

    // ------------------------------------------------------------------
    // Digit chain
    // ------------------------------------------------------------------
    lim_digit #(.L(HUND_LIM))     u_hund_ones (.a(r_d0), .ci(w_tick), .sum(w_s0), .co(w_c0));
    lim_digit #(.L(HUND_LIM))     u_hund_tens (.a(r_d1), .ci(w_c0),   .sum(w_s1), .co(w_c1));
    lim_digit #(.L(SEC_ONES_LIM)) u_sec_ones  (.a(r_d2), .ci(w_c1),   .sum(w_s2), .co(w_c2));
    lim_digit #(.L(SEC_TENS_LIM)) u_sec_tens  (.a(r_d3), .ci(w_c2),   .sum(w_s3), .co(w_wrap));

    // Both a clear into IDLE and the 59.99 rollover land on 00.00
    assign w_zero = (w_next == IDLE) || w_wrap;

    always_ff @(posedge clk) begin
        if (reset || w_zero) begin
            r_d0 <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
        end else begin
            r_d0 <= w_s0;
            r_d1 <= w_s1;
            r_d2 <= w_s2;
            r_d3 <= w_s3;
        end
    end

    assign running   = r_running;
    assign tick      = w_tick;
    assign hund_ones = r_d0;
    assign hund_tens = r_d1;
    assign sec_ones  = r_d2;
    assign sec_tens  = r_d3;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_counter
//  Description : Randomised scoreboard bench for stopwatch_counter against an
//                elapsed-hundredths reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_counter;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       running;
    logic       tick;
    logic [3:0] hund_ones;
    logic [3:0] hund_tens;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;

    stopwatch_counter #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .running    (running),
        .tick       (tick),
        .hund_ones  (hund_ones),
        .hund_tens  (hund_tens),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic run;
        logic tk;
        int   elapsed;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    // Reference model: elapsed hundredths, phase within the tick interval,
    // and whether the watch is running / holding a non-cleared time.
    int m_elapsed;
    int m_phase;
    bit m_running;
    bit m_holding;

    function automatic bit model_tick();
        return m_running && (m_phase == TICK_DIV - 1);
    endfunction

    task automatic model_reset();
        m_elapsed = 0;
        m_phase   = 0;
        m_running = 0;
        m_holding = 0;
    endtask

    task automatic model_edge(input bit rs, input bit ss, input bit cl);
        if (rs) begin
            model_reset();
        end else begin
            if (model_tick()) m_elapsed = (m_elapsed + 1) % 6000;
            if (m_running) m_phase = (m_phase + 1) % TICK_DIV;
            if (m_running) begin
                if (ss) begin
                    m_running = 0;
                    m_holding = 1;
                end
            end else if (cl) begin
                model_reset();
            end else if (ss) begin
                m_running = 1;
                m_holding = 0;
            end
        end
    endtask

    task automatic step(input bit rs, input bit ss, input bit cl);
        exp_t e;
        reset      = rs;
        start_stop = ss;
        clear      = cl;
        e.run      = m_running;
        e.tk       = model_tick();
        e.elapsed  = m_elapsed;
        q_exp.push_back(e);
        model_edge(rs, ss, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("running",   int'(running),   int'(e.run));
                chk("tick",      int'(tick),      int'(e.tk));
                chk("hund_ones", int'(hund_ones), e.elapsed % 10);
                chk("hund_tens", int'(hund_tens), (e.elapsed / 10) % 10);
                chk("sec_ones",  int'(sec_ones),  (e.elapsed / 100) % 10);
                chk("sec_tens",  int'(sec_tens),  e.elapsed / 1000);
                if (n_fail >= 50 && !done) begin
                    done = 1;
                    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                    $finish;
                end
            end
        end
    end

    initial begin
        int r;
        int guard;
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state, then start and observe the first ticks
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (50) step(0, 0, 0);

        // Clear while running is ignored
        step(0, 0, 1);
        repeat (10) step(0, 0, 0);

        // Stop two cycles after a tick, hold 20 cycles, resume
        guard = 0;
        while (!model_tick() && guard < 10) begin
            step(0, 0, 0);
            guard++;
        end
        step(0, 0, 0);
        step(0, 0, 0);
        step(0, 1, 0);
        repeat (20) step(0, 0, 0);
        step(0, 1, 0);
        repeat (12) step(0, 0, 0);

        // Run through 59.99 -> 00.00 and beyond
        repeat (6000 * TICK_DIV + 40) step(0, 0, 0);

        // Simultaneous start_stop and clear: in RUN -> HOLD, then in HOLD -> IDLE
        step(0, 1, 1);
        repeat (5) step(0, 0, 0);
        step(0, 1, 1);
        repeat (5) step(0, 0, 0);
        step(0, 1, 1);
        repeat (5) step(0, 0, 0);

        // Random pulses
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            step(r == 0, (r >= 1 && r < 6) || (r >= 10 && r < 13), r >= 6 && r < 13);
        end

        // Reset mid-run at 12.34 with a coincident start_stop
        step(1, 0, 0);
        step(0, 1, 0);
        guard = 0;
        while (m_elapsed != 1234 && guard < 10000) begin
            step(0, 0, 0);
            guard++;
        end
        chk("reach_1234", m_elapsed, 1234);
        step(1, 1, 0);
        repeat (8) step(0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q_exp.size(), 0);
        if (!done) begin
            done = 1;
            $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        end
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Stopwatch time base and digit chain for the Basys3 stopwatch: ss.hh format, 00.00 to 59.99, wrapping to 00.00.
- A prescaler divides clk into hundredth-second ticks.
- A start/stop/clear FSM gates counting.
- Four cascaded limited-incrementor digits produce the BCD values consumed downstream by the 7-segment display driver.

Parameters:
- TICK_DIV, 1_000_000, clk cycles per hundredth-second tick (100 MHz / 100 Hz). Benches override it to a small value. Legal range 2 and up.
- CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high; all state to reset values.
- start_stop  in  1  single-cycle pulse, already debounced; toggles run/hold.
- clear  in  1  single-cycle pulse, already debounced; zeroes time when not running.
- running  out  1  high in RUN state.
- tick  out  1  one-cycle pulse on each hundredth increment.
- hund_ones  out  4  BCD 0-9.
- hund_tens  out  4  BCD 0-9.
- sec_ones  out  4  BCD 0-9.
- sec_tens  out  4  BCD 0-5.

Behaviour:
- Reset:
  - FSM = IDLE; prescaler = 0.
  - All digits = 0; running = 0; tick = 0.
  - Reset overrides every other input on the same edge.
- FSM states: IDLE (time zero, stopped), RUN, HOLD (stopped, time retained).
- Transitions:
  - IDLE --start_stop--> RUN.
  - RUN --start_stop--> HOLD.
  - HOLD --start_stop--> RUN.
  - HOLD --clear--> IDLE.
  - IDLE --clear--> IDLE (no effect).
  - clear in RUN is ignored.
- Simultaneous start_stop and clear:
  - In RUN: start_stop wins, go to HOLD; clear is dropped.
  - In HOLD or IDLE: clear wins, go to IDLE; start_stop is dropped.
- running is a registered decode of the state: high in the cycle after the transition edge.
- Prescaler:
  - Counts only in RUN, from 0 to TICK_DIV-1, then wraps to 0.
  - Holds its value in HOLD, so a resume keeps the partial interval.
  - Forced to 0 on entry to IDLE.
- tick:
  - Combinational: (state == RUN) && (prescaler == TICK_DIV-1).
  - Exactly one cycle wide, every TICK_DIV cycles while running.
- Digit chain:
  - On the clk edge where tick is high, hund_ones increments.
  - Each digit is a limited incrementor, in order: hund_ones (L=9), hund_tens (L=9), sec_ones (L=9), sec_tens (L=5).
  - Rule per digit: if digit == L and carry-in is 1, the digit becomes 0 and carry-out = 1. Otherwise digit + carry-in, carry-out = 0.
  - Carry-in of each digit is the carry-out of the one below it; hund_ones carry-in = tick.
  - The chain is combinational; all digits register on the same edge.
  - New digit values are visible the cycle after tick.
- Wrap: 59.99 plus a tick gives 00.00. There is no overflow flag; counting continues.
- Digit values are always in range; out-of-range states are unreachable.
- start_stop on the same edge as tick in RUN: the increment still happens on that edge, then the FSM enters HOLD.
- Entry to IDLE via clear sets all digits to 0 on the same edge.

Decomposition:
- Shared package stopwatch_pkg holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, HOLD=2'd2.
  - Digit limits: HUND_LIM=9, SEC_ONES_LIM=9, SEC_TENS_LIM=5.
  - BCD width constant: 4.
- Sub-module: lim_digit. It is a 4-bit limited incrementor parameterised by L, with ports a, ci, sum, co. Instantiate it four times.
- The registers, prescaler and FSM stay in stopwatch_counter.

Test Plan (TICK_DIV=4):
1. Reset → pulse start_stop → exactly 4 cycles later tick pulses. The next cycle shows hund_ones=1; running=1 from the cycle after the pulse.
2. Run for 10 ticks → 00.10: hund_tens=1, hund_ones=0. The carry propagates on the same edge as the 10th tick.
3. Preload by running to 59.99, then one more tick → all digits 0, running still 1, counting continues to 00.01.
4. In RUN, pulse start_stop two cycles after a tick → HOLD, digits frozen for 20 cycles. Pulse start_stop again → the next tick arrives 2 cycles later, because the partial interval is retained.
5. In RUN, pulse clear → ignored, digits continue. Then start_stop and clear together in HOLD → IDLE, digits 00.00, prescaler 0, running 0.
6. Assert reset mid-run at 12.34 → next cycle all digits 0, running=0, tick=0. A start_stop in the same cycle as reset is ignored.
